io_window_decoder: RTL

Parametrised, registered successor to the fixed I/O address decoder. It decodes CPU I/O cycles against NUM_WIN runtime-programmable base/mask windows and drives one-hot, registered chip selects. It responds to unclaimed ports itself, and terminates any window that fails to acknowledge within a bounded time, logging the fault. It sits between the CPU data-master bus and the I/O peripherals (PIC, PIT, DMA, UARTs, video, floppy) and replaces hard-coded port constants.

---
 rtl/io_window_decoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/io_window_decoder.sv
// rtl/io_window_decoder.sv - registered base/mask I/O window decoder with default responder and ack timeout
module io_window_decoder #(
    parameter int                      NUM_WIN     = 8,
    parameter logic [NUM_WIN*16-1:0]   RST_BASE    = {NUM_WIN{16'h0000}},
    parameter logic [NUM_WIN*16-1:0]   RST_MASK    = {NUM_WIN{16'h0000}},
    parameter logic [NUM_WIN-1:0]      RST_EN      = {NUM_WIN{1'b0}},
    parameter int                      TIMEOUT     = 32,
    parameter int                      DEFAULT_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               d_io,
    input  logic [19:1]        data_m_addr,
    input  logic               data_m_access,
    input  logic [NUM_WIN-1:0] win_ack,
    output logic [NUM_WIN-1:0] win_sel,
    output logic               default_sel,
    output logic               default_ack,
    output logic               timeout_ack,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_idx,
    input  logic [15:0]        cfg_base,
    input  logic [15:0]        cfg_mask,
    input  logic               cfg_en,
    output logic               err_valid,
    output logic [15:0]        err_addr,
    output logic [3:0]         err_win,
    input  logic               err_clr
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WIN, DFLT, DROP} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_WIN-1:0] win_sel_q;
    logic               default_sel_q, default_ack_q, timeout_ack_q;
    logic               err_valid_q;
    logic [15:0]        err_addr_q, addr_q;
    logic [3:0]         err_win_q, idx_q;

    logic [15:0]        base_q [NUM_WIN];
    logic [15:0]        mask_q [NUM_WIN];
    logic [NUM_WIN-1:0] en_q;

    logic [15:0]        port;
    logic               unused_addr;
    logic               hit;
    logic [3:0]         hit_idx;
    logic [NUM_WIN-1:0] sel_vec;

    assign port        = {data_m_addr[15:1], 1'b0};
    assign unused_addr = ^data_m_addr[19:16];

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        sel_vec = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (en_q[i] && ((port & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
        for (int i = 0; i < NUM_WIN; i++) begin
            sel_vec[i] = hit && (hit_idx == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                base_q[i] <= RST_BASE[16*i +: 16];
                mask_q[i] <= RST_MASK[16*i +: 16];
            end
            en_q <= RST_EN;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_idx == 4'(i)) begin
                    base_q[i] <= cfg_base;
                    mask_q[i] <= cfg_mask;
                    en_q[i]   <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            win_sel_q     <= '0;
            default_sel_q <= 1'b0;
            default_ack_q <= 1'b0;
            timeout_ack_q <= 1'b0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= 16'h0000;
            err_win_q     <= 4'd0;
            addr_q        <= 16'h0000;
            idx_q         <= 4'd0;
        end else begin
            default_ack_q <= 1'b0;
            timeout_ack_q <= 1'b0;
            if (err_clr) begin
                err_valid_q <= 1'b0;
                err_addr_q  <= 16'h0000;
                err_win_q   <= 4'd0;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (d_io && data_m_access) begin
                        addr_q <= port;
                        idx_q  <= hit_idx;
                        if (hit) begin
                            win_sel_q <= sel_vec;
                            state_q   <= WIN;
                        end else begin
                            default_sel_q <= 1'b1;
                            state_q       <= DFLT;
                        end
                    end
                end
                WIN: begin
                    // An ack on the final cycle beats the timeout.
                    if (|(win_ack & win_sel_q)) begin
                        win_sel_q <= '0;
                        state_q   <= DROP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_ack_q <= 1'b1;
                        win_sel_q     <= '0;
                        state_q       <= DROP;
                        if (!err_valid_q && !err_clr) begin
                            err_valid_q <= 1'b1;
                            err_addr_q  <= addr_q;
                            err_win_q   <= idx_q;
                        end
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DFLT: begin
                    if (cnt_q == CW'(DEFAULT_LAT - 1)) begin
                        default_ack_q <= 1'b1;
                        default_sel_q <= 1'b0;
                        state_q       <= DROP;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DROP: begin
                    if (!data_m_access) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign win_sel     = win_sel_q;
    assign default_sel = default_sel_q;
    assign default_ack = default_ack_q;
    assign timeout_ack = timeout_ack_q;
    assign err_valid   = err_valid_q;
    assign err_addr    = err_addr_q;
    assign err_win     = err_win_q;

endmodule
